// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state and iteration-mode types for alu_seq     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

  // Bits needed for an iteration counter that must hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_iter_unit : shared shift-add / restoring-division datapath        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  iter_mode_t         i_mode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc_next,
  output logic [WIDTH-1:0]   o_sr_next
);

  // r_acc: product accumulator or partial remainder (low WIDTH bits).
  // r_sr : multiplier shifting out LSB-first, or dividend/quotient shifting left.
  // r_opd: multiplicand shifting left, or divisor (low WIDTH bits).
  iter_mode_t         r_mode;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_sr;
  logic [2*WIDTH-1:0] r_opd;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_sr_next;
  logic [2*WIDTH-1:0] w_opd_next;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_dvs;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;

  assign w_sh  = {r_acc[WIDTH-1:0], r_sr[WIDTH-1]};
  assign w_dvs = {1'b0, r_opd[WIDTH-1:0]};
  assign w_ge  = (w_sh >= w_dvs);
  // Only used when w_ge, so the true difference is below the divisor and fits.
  assign w_sub = w_sh[WIDTH-1:0] - r_opd[WIDTH-1:0];

  always_comb begin
    w_acc_next = r_acc;
    w_sr_next  = r_sr;
    w_opd_next = r_opd;
    if (r_mode == MODE_MUL) begin
      if (r_sr[0]) begin
        w_acc_next = r_acc + r_opd;
      end
      w_sr_next  = r_sr >> 1;
      w_opd_next = r_opd << 1;
    end else begin
      w_acc_next = {{WIDTH{1'b0}}, (w_ge ? w_sub : w_sh[WIDTH-1:0])};
      w_sr_next  = {r_sr[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_MUL;
      r_acc  <= '0;
      r_sr   <= '0;
      r_opd  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_acc  <= '0;
      r_sr   <= (i_mode == MODE_MUL) ? i_b : i_a;
      r_opd  <= {{WIDTH{1'b0}}, ((i_mode == MODE_MUL) ? i_a : i_b)};
    end else if (i_step) begin
      r_acc  <= w_acc_next;
      r_sr   <= w_sr_next;
      r_opd  <= w_opd_next;
    end
  end

  assign o_acc_next = w_acc_next;
  assign o_sr_next  = w_sr_next;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq : multi-cycle ALU with start/busy/done handshake              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [2:0]         i_ctrl,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_neg,
  output logic               o_div_zero
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_ctrl;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_result;
  logic             r_neg;
  logic             r_div_zero;

  logic [RW-1:0]    w_fast_result;
  logic             w_fast_neg;
  logic             w_fast_dz;
  logic             w_needs_iter;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [RW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_sr_next;
  logic [RW-1:0]    w_iter_result;
  iter_mode_t       w_mode;

  assign w_b_zero = (i_b == '0);
  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff   = i_a - i_b;
  assign w_mode   = (i_ctrl == OP_MUL) ? MODE_MUL : MODE_DIV;

  // Single-cycle ops resolve straight from the inputs on the accepting edge.
  always_comb begin
    w_fast_result = '0;
    w_fast_neg    = 1'b0;
    w_fast_dz     = 1'b0;
    w_needs_iter  = 1'b0;
    case (i_ctrl)
      OP_ADD: w_fast_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB: begin
        w_fast_result = {{WIDTH{1'b0}}, w_diff};
        w_fast_neg    = (i_a < i_b);
      end
      OP_MUL: w_needs_iter = 1'b1;
      OP_DIV: begin
        if (w_b_zero) begin
          w_fast_result = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          w_fast_dz     = 1'b1;
        end else begin
          w_needs_iter = 1'b1;
        end
      end
      OP_MOD: begin
        if (w_b_zero) begin
          w_fast_result = {{WIDTH{1'b0}}, i_a};
          w_fast_dz     = 1'b1;
        end else begin
          w_needs_iter = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_last_step = (r_state == ST_CALC) && (r_cnt == CW'(1));

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept && w_needs_iter),
    .i_step    (r_state == ST_CALC),
    .i_mode    (w_mode),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_acc_next(w_acc_next),
    .o_sr_next (w_sr_next)
  );

  assign w_iter_result = (r_ctrl == OP_DIV) ? {{WIDTH{1'b0}}, w_sr_next} : w_acc_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = w_needs_iter ? ST_CALC : ST_DONE;
      ST_CALC: if (r_cnt == CW'(1)) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_neg      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ctrl <= i_ctrl;
      end
      if (w_accept && w_needs_iter) begin
        r_cnt <= CW'(WIDTH);
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_accept && !w_needs_iter) begin
        r_result   <= w_fast_result;
        r_neg      <= w_fast_neg;
        r_div_zero <= w_fast_dz;
      end else if (w_last_step) begin
        r_result   <= w_iter_result;
        r_neg      <= 1'b0;
        r_div_zero <= 1'b0;
      end
    end
  end

  assign o_result   = r_result;
  assign o_neg      = r_neg;
  assign o_div_zero = r_div_zero;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);

endmodule
`default_nettype wire
